// File: rtl/fifo_sync_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Holds the read-mode encodings, the pointer-width function and the parameter legality check.
package fifo_sync_pkg;

  localparam logic [63:0] MODE_STANDARD = "STANDARD";
  localparam logic [63:0] MODE_FWFT     = "FWFT";

  function automatic int fifo_aw(input int depth);
    return $clog2(depth);
  endfunction

  // Legal: width 1..72, power-of-two depth 4..32768, known mode, 1 <= PE < PF <= DEPTH-1.
  function automatic bit fifo_params_ok(input int dw, input int depth,
                                        input logic [63:0] mode,
                                        input int pe, input int pf);
    bit ok;
    ok = (dw >= 1) && (dw <= 72);
    ok = ok && (depth >= 4) && (depth <= 32768) && ((depth & (depth - 1)) == 0);
    ok = ok && ((mode == MODE_STANDARD) || (mode == MODE_FWFT));
    ok = ok && (pe >= 1) && (pe < pf) && (pf <= depth - 1);
    return ok;
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port storage array: synchronous write, registered or combinational read.
// The registered read port loads only when re_i is high and clears on reset.
module fifo_sync_ram #(
  parameter int WIDTH    = 18,
  parameter int DEPTH    = 1024,
  parameter int AW       = 10,
  parameter bit REG_READ = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  if (REG_READ) begin : g_reg_read
    logic [WIDTH-1:0] rdata_q;
    always_ff @(posedge clk_i) begin
      if (rst_i)     rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
    end
    assign rdata_o = rdata_q;
  end else begin : g_comb_read
    // Combinational read has no use for the load/reset controls.
    logic unused_ctrl;
    assign unused_ctrl = rst_i ^ re_i;
    assign rdata_o     = mem_q[raddr_i];
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with STANDARD/FWFT read modes and a full registered flag set.
// Optional per-word even parity is enabled by defining FIFO_SYNC_PARITY_EN.
module fifo_sync_param
  import fifo_sync_pkg::*;
#(
  parameter int          DATA_WIDTH        = 18,
  parameter int          DEPTH             = 1024,
  parameter logic [63:0] MODE              = MODE_STANDARD,
  parameter int          PROG_EMPTY_THRESH = 4,
  parameter int          PROG_FULL_THRESH  = DEPTH - 6
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     WR_EN,
  input  logic [DATA_WIDTH-1:0]    WR_DATA,
  input  logic                     RD_EN,
  output logic [DATA_WIDTH-1:0]    RD_DATA,
  output logic [fifo_aw(DEPTH):0]  COUNT,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic                     ALMOST_EMPTY,
  output logic                     ALMOST_FULL,
  output logic                     PROG_EMPTY,
  output logic                     PROG_FULL,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW,
  output logic                     PARITY_ERR
);

  localparam int AW      = fifo_aw(DEPTH);
  localparam int CW      = AW + 1;
  localparam bit IS_FWFT = (MODE == MODE_FWFT);
`ifdef FIFO_SYNC_PARITY_EN
  localparam int SW = DATA_WIDTH + 1;
`else
  localparam int SW = DATA_WIDTH;
`endif

  if (!fifo_params_ok(DATA_WIDTH, DEPTH, MODE, PROG_EMPTY_THRESH, PROG_FULL_THRESH)) begin : g_param_err
    $fatal(1, "fifo_sync_param: illegal parameters DATA_WIDTH=%0d DEPTH=%0d PE=%0d PF=%0d",
           DATA_WIDTH, DEPTH, PROG_EMPTY_THRESH, PROG_FULL_THRESH);
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, full_q, aempty_q, afull_q, pempty_q, pfull_q;
  logic          ovf_q, udf_q;
  logic          wr_acc, rd_acc;
  logic [SW-1:0] wdata_s, rdata_s;

  // Handshake: a write is taken iff WR_EN && !FULL, a read iff RD_EN && !EMPTY, both judged
  // on the registered flags; a rejected request is dropped and reported one cycle later.
  always_comb begin
    wr_acc   = WR_EN && !full_q;
    rd_acc   = RD_EN && !empty_q;
    wr_ptr_d = wr_ptr_q + AW'(wr_acc);
    rd_ptr_d = rd_ptr_q + AW'(rd_acc);
    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b0;
      afull_q  <= 1'b0;
      pempty_q <= 1'b1;
      pfull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // Flags are derived from the post-edge count so they never lag the operation.
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == CW'(DEPTH));
      aempty_q <= (count_d == CW'(1));
      afull_q  <= (count_d == CW'(DEPTH - 1));
      pempty_q <= (count_d <= CW'(PROG_EMPTY_THRESH));
      pfull_q  <= (count_d >= CW'(PROG_FULL_THRESH));
      ovf_q    <= WR_EN && full_q;
      udf_q    <= RD_EN && empty_q;
    end
  end

`ifdef FIFO_SYNC_PARITY_EN
  assign wdata_s = {^WR_DATA, WR_DATA};
`else
  assign wdata_s = WR_DATA;
`endif

  fifo_sync_ram #(
    .WIDTH    (SW),
    .DEPTH    (DEPTH),
    .AW       (AW),
    .REG_READ (!IS_FWFT)
  ) u_ram (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata_s),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata_s)
  );

  assign RD_DATA = rdata_s[DATA_WIDTH-1:0];

`ifdef FIFO_SYNC_PARITY_EN
  if (IS_FWFT) begin : g_par_fwft
    // The popped word is on the bus before the edge; flag it right after the pop.
    logic par_err_q;
    always_ff @(posedge CLK) begin
      if (RESET) par_err_q <= 1'b0;
      else       par_err_q <= rd_acc && (^rdata_s);
    end
    assign PARITY_ERR = par_err_q;
  end else begin : g_par_std
    logic rd_vld_q;
    always_ff @(posedge CLK) begin
      if (RESET) rd_vld_q <= 1'b0;
      else       rd_vld_q <= rd_acc;
    end
    assign PARITY_ERR = rd_vld_q && (^rdata_s);
  end
`else
  assign PARITY_ERR = 1'b0;
`endif

  assign COUNT        = count_q;
  assign EMPTY        = empty_q;
  assign FULL         = full_q;
  assign ALMOST_EMPTY = aempty_q;
  assign ALMOST_FULL  = afull_q;
  assign PROG_EMPTY   = pempty_q;
  assign PROG_FULL    = pfull_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a STANDARD instance checked by a queue model and read-data
// scoreboard, plus an FWFT instance checked against the same queue-style model.
module tb_fifo_sync_param;
  import fifo_sync_pkg::*;

  localparam int DW = 18, DEPTH = 16, PE = 4, PF = 12, CW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          s_wr, s_rd, f_wr, f_rd;
  logic [DW-1:0] s_wdata, s_rdata, f_wdata, f_rdata;
  logic [CW-1:0] s_count, f_count;
  logic s_empty, s_full, s_ae, s_af, s_pe, s_pf, s_ovf, s_udf, s_perr;
  logic f_empty, f_full, f_ae, f_af, f_pe, f_pf, f_ovf, f_udf, f_perr;

  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PROG_EMPTY_THRESH(PE),
                    .PROG_FULL_THRESH(PF)) dut_std (
    .CLK(clk), .RESET(rst), .WR_EN(s_wr), .WR_DATA(s_wdata), .RD_EN(s_rd),
    .RD_DATA(s_rdata), .COUNT(s_count), .EMPTY(s_empty), .FULL(s_full),
    .ALMOST_EMPTY(s_ae), .ALMOST_FULL(s_af), .PROG_EMPTY(s_pe), .PROG_FULL(s_pf),
    .OVERFLOW(s_ovf), .UNDERFLOW(s_udf), .PARITY_ERR(s_perr));

  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MODE(MODE_FWFT),
                    .PROG_EMPTY_THRESH(PE), .PROG_FULL_THRESH(PF)) dut_fwft (
    .CLK(clk), .RESET(rst), .WR_EN(f_wr), .WR_DATA(f_wdata), .RD_EN(f_rd),
    .RD_DATA(f_rdata), .COUNT(f_count), .EMPTY(f_empty), .FULL(f_full),
    .ALMOST_EMPTY(f_ae), .ALMOST_FULL(f_af), .PROG_EMPTY(f_pe), .PROG_FULL(f_pf),
    .OVERFLOW(f_ovf), .UNDERFLOW(f_udf), .PARITY_ERR(f_perr));

  // ---------------- scoreboard / model state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];   // expected STANDARD read words, in order
  logic [DW-1:0] mq[$];      // STANDARD model contents
  logic [DW-1:0] fq[$];      // FWFT model contents
  logic [DW-1:0] m_rd;       // STANDARD model of the held RD_DATA

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Flags are recomputed from the model occupancy n using the plain definitions.
  task automatic check_status(input string tag, input int n, input bit e_ovf, input bit e_udf,
                              input logic [CW-1:0] cnt, input logic e, input logic f,
                              input logic ae, input logic af, input logic pe, input logic pf,
                              input logic ov, input logic ud);
    check({tag, "_count"},        32'(cnt), 32'(n));
    check({tag, "_empty"},        32'(e),   32'(n == 0));
    check({tag, "_full"},         32'(f),   32'(n == DEPTH));
    check({tag, "_almost_empty"}, 32'(ae),  32'(n == 1));
    check({tag, "_almost_full"},  32'(af),  32'(n == DEPTH - 1));
    check({tag, "_prog_empty"},   32'(pe),  32'(n <= PE));
    check({tag, "_prog_full"},    32'(pf),  32'(n >= PF));
    check({tag, "_overflow"},     32'(ov),  32'(e_ovf));
    check({tag, "_underflow"},    32'(ud),  32'(e_udf));
  endtask

  // ---------------- driver tasks ----------------
  // One STANDARD-instance cycle: drive at the falling edge, update the model, check after the edge.
  task automatic step(input bit r, input bit w, input logic [DW-1:0] d, input bit rd);
    int n;
    bit e_ovf, e_udf, rok;
    rst = r; s_wr = w; s_wdata = d; s_rd = rd;
    n = mq.size();
    e_ovf = !r && w && (n == DEPTH);
    e_udf = !r && rd && (n == 0);
    rok = 1'b0;
    if (r) begin
      mq.delete();
      m_rd = '0;
    end else begin
      rok = rd && (n > 0);
      if (rok) begin
        m_rd = mq.pop_front();
        exp_q.push_back(m_rd);
      end
      if (w && (n < DEPTH)) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    check_status("std", mq.size(), e_ovf, e_udf, s_count, s_empty, s_full, s_ae, s_af,
                 s_pe, s_pf, s_ovf, s_udf);
    if (!rok) check("std_rd_hold", 32'(s_rdata), 32'(m_rd));
    @(negedge clk);
  endtask

  task automatic fstep(input bit w, input logic [DW-1:0] d, input bit rd);
    int n;
    bit e_ovf, e_udf;
    f_wr = w; f_wdata = d; f_rd = rd;
    n = fq.size();
    e_ovf = w && (n == DEPTH);
    e_udf = rd && (n == 0);
    if (rd && (n > 0)) void'(fq.pop_front());
    if (w && (n < DEPTH)) fq.push_back(d);
    @(posedge clk);
    #1;
    check_status("fwft", fq.size(), e_ovf, e_udf, f_count, f_empty, f_full, f_ae, f_af,
                 f_pe, f_pf, f_ovf, f_udf);
    if (fq.size() > 0) check("fwft_head", 32'(f_rdata), 32'(fq[0]));
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  // Whenever the STANDARD instance accepts a read, the next RD_DATA must be the queue head.
  initial begin
    forever begin
      bit acc;
      logic [DW-1:0] e;
      @(posedge clk);
      acc = s_rd && !s_empty && !rst;
      #1;
      if (acc) begin
        if (exp_q.size() == 0) begin
          check("std_rd_unexpected", 32'(s_rdata), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("std_rd_data", 32'(s_rdata), 32'(e));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; s_wr = 1'b0; s_rd = 1'b0; s_wdata = '0;
    f_wr = 1'b0; f_rd = 1'b0; f_wdata = '0; m_rd = '0;
    @(negedge clk);
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);

    // Fill 1..16, then an overflowing 17th write.
    for (int i = 1; i <= DEPTH; i++) step(0, 1, DW'(i), 0);
    step(0, 1, 18'h00011, 0);
    step(0, 0, '0, 0);

    // Drain, then underflow alone and simultaneous read+write at empty.
    for (int i = 0; i < DEPTH; i++) step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 0);
    step(0, 1, 18'h1_2345, 1);

    // Bring occupancy to 8, then 40 cycles of concurrent read and write.
    for (int i = 0; i < 7; i++) step(0, 1, DW'($urandom_range(0, 32'h3FFFF)), 0);
    for (int i = 0; i < 40; i++) step(0, 1, DW'($urandom_range(0, 32'h3FFFF)), 1);

    // Random traffic: write-heavy, read-heavy, then balanced.
    for (int i = 0; i < 300; i++) begin
      bit w, rd;
      if (i < 100) begin
        w = ($urandom_range(0, 3) != 0); rd = ($urandom_range(0, 3) == 0);
      end else if (i < 200) begin
        w = ($urandom_range(0, 3) == 0); rd = ($urandom_range(0, 3) != 0);
      end else begin
        w = ($urandom_range(0, 1) == 1); rd = ($urandom_range(0, 1) == 1);
      end
      step(0, w, DW'($urandom_range(0, 32'h3FFFF)), rd);
    end

    // Reset with nine words stored and a write pending.
    while (mq.size() > 0) step(0, 0, '0, 1);
    for (int i = 0; i < 9; i++) step(0, 1, DW'($urandom_range(0, 32'h3FFFF)), 0);
    step(1, 1, 18'h3_FFFF, 0);
    step(0, 0, '0, 0);

    // FWFT: first word appears with EMPTY falling; popping it empties the FIFO.
    fstep(1, 18'h2AAAA, 0);
    fstep(0, '0, 1);
    fstep(0, '0, 1);
    for (int i = 0; i < 200; i++) begin
      bit w, rd;
      w  = (i < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 1) == 1);
      fstep(w, DW'($urandom_range(0, 32'h3FFFF)), rd);
    end

    repeat (2) @(negedge clk);
    check("std_scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
